// File: rtl/fetch_unit.sv
// Instruction fetch stage for the 9-bit core: PC, ROM addressing, one-bubble branch flush, halt detect.
// Optional FETCH_CYCLE_CNT_EN adds a saturating CycleCnt output counting RUN-state edges.
module fetch_unit #(
  parameter int unsigned      PC_W      = 10,
  parameter int unsigned      IW        = 9,
  parameter logic [IW-1:0]    HALT_WORD = 9'b011111111
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [IW-1:0]     InstrIn,
  input  logic              Stall,
  input  logic              BranchTaken,
  input  logic [PC_W-1:0]   BranchTarget,
  output logic [PC_W-1:0]   PC,
  output logic [IW-1:0]     Instr,
  output logic              Valid,
  output logic              Done
`ifdef FETCH_CYCLE_CNT_EN
  ,
  output logic [15:0]       CycleCnt
`endif
);

  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

  localparam logic [PC_W-1:0] PcOne = PC_W'(1);

  state_e state_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StBoot;
      PC      <= '0;
      Instr   <= '0;
      Valid   <= 1'b0;
      Done    <= 1'b0;
    end else begin
      unique case (state_q)
        StBoot: begin
          Instr   <= InstrIn;
          Valid   <= 1'b1;
          PC      <= PC + PcOne;
          state_q <= StRun;
        end
        StRun: begin
          // Halt wins over stall so a held halt word still terminates the program.
          if (Valid && (Instr == HALT_WORD)) begin
            state_q <= StHalt;
            Done    <= 1'b1;
            Valid   <= 1'b0;
          end else if (Stall) begin
            state_q <= StRun;
          end else if (BranchTaken && Valid) begin
            PC    <= BranchTarget;
            Instr <= '0;
            Valid <= 1'b0;
          end else begin
            Instr <= InstrIn;
            Valid <= 1'b1;
            PC    <= PC + PcOne;
          end
        end
        StHalt: begin
          state_q <= StHalt;
        end
        default: begin
          state_q <= StBoot;
        end
      endcase
    end
  end

`ifdef FETCH_CYCLE_CNT_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      CycleCnt <= '0;
    end else if ((state_q == StRun) && (CycleCnt != 16'hFFFF)) begin
      CycleCnt <= CycleCnt + 16'd1;
    end
  end
`endif

endmodule
